// File: rtl/counters_sample_fifo.sv
// counters_sample_fifo
//   Samples the counter sum bus once every PERIOD enabled clocks, computes the
//   modular delta from the previous sample and buffers {sample, delta, first}
//   entries in a small FIFO drained through a valid/ready port. A push into a
//   full FIFO (with no simultaneous pop) is discarded and counted in drop_cnt.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   en         sampling enable; phase counter and sampler advance only while high
//   in_val     sum bus from the counters stage
//   out_valid  FIFO non-empty, head entry presented on out_*
//   out_ready  consumer accepts the head entry this cycle
//   out_data   head entry: sampled value
//   out_delta  head entry: sample minus previous sample, mod 2^WIDTH
//   out_first  head entry: first sample since reset
//   fill       current FIFO occupancy
//   drop_cnt   discarded samples, saturating at 255
//
// Sampler states
//   state | meaning
//   PRIME | no sample taken since reset; next capture has first=1, delta=0
//   RUN   | prev holds the last captured value; deltas are computed from it
module counters_sample_fifo #(
    parameter int WIDTH  = 16,
    parameter int PERIOD = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         in_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [WIDTH-1:0]         out_delta,
    output logic                     out_first,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [7:0]               drop_cnt
);

    localparam int PW = $clog2(PERIOD);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * WIDTH + 1;

    typedef enum logic {PRIME, RUN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    phase;
    logic [WIDTH-1:0] prev;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [7:0]       drops;
    logic [EW-1:0]    mem [DEPTH];

    logic             capture, pop, full, push_ok, drop;
    logic [EW-1:0]    entry;

    assign capture = en && (phase == PW'(PERIOD - 1));
    assign pop     = out_valid && out_ready;
    assign full    = (count == (AW+1)'(DEPTH));
    // When full, a same-edge pop frees the slot the push writes into
    // (wr_ptr == rd_ptr), and the pop reads the old contents before the write.
    assign push_ok = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        state_d = state_q;
        entry   = {in_val, {WIDTH{1'b0}}, 1'b1};
        if (state_q == RUN) begin
            entry = {in_val, in_val - prev, 1'b0};
        end
        if (capture) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            prev  <= '0;
        end else begin
            if (en) begin
                if (phase == PW'(PERIOD - 1)) begin
                    phase <= '0;
                end else begin
                    phase <= phase + PW'(1);
                end
            end
            // prev follows every capture, even when the push is dropped.
            if (capture) begin
                prev <= in_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drops  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop && (drops != 8'hFF)) begin
                drops <= drops + 8'd1;
            end
        end
    end

    assign out_valid = (count != '0);
    assign {out_data, out_delta, out_first} = mem[rd_ptr];
    assign fill      = count;
    assign drop_cnt  = drops;

endmodule

// File: doc/counters_sample_fifo.md
# counters_sample_fifo

Downstream consumer of the 4-counter sum bus. Samples the sum once every PERIOD clocks, computes the modular delta from the previous sample, and buffers {sample, delta, first} entries in a small FIFO. A valid/ready interface drains the FIFO to a checker or logging stage; overruns are counted, never stalled.

## Interface
- WIDTH, 16: width of the sampled sum bus (2×counter SIZE).
- PERIOD, 4: clocks between samples; must be ≥2. The default matches the 4-phase counter select rotation.
- DEPTH, 4: FIFO entries; must be a power of two and ≥2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  sampling enable; phase counter and sampler advance only while high.
- in_val  in  WIDTH  sum bus from the counters stage.
- out_valid  out  1  FIFO non-empty; head entry is presented.
- out_ready  in  1  consumer accepts the head entry this cycle.
- out_data  out  WIDTH  head entry: sampled value.
- out_delta  out  WIDTH  head entry: sample minus previous sample, mod 2^WIDTH.
- out_first  out  1  head entry: first sample since reset (delta forced to 0).
- fill  out  clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  8  samples discarded due to a full FIFO; saturates at 255.

## Operation
- Sampler FSM has two states: PRIME and RUN. Reset enters PRIME.
- Phase counter spans 0..PERIOD-1, reset to 0. It increments on each edge with en=1, wraps PERIOD-1 → 0, and holds when en=0.
- Capture occurs on an edge where en=1 and phase==PERIOD-1. The value captured is in_val as sampled at that edge.
- Capture in PRIME:
  - prev ← in_val.
  - Push {in_val, 0, first=1}.
  - Go to RUN.
- Capture in RUN:
  - Push {in_val, in_val − prev (WIDTH-bit wraparound), first=0}.
  - prev ← in_val.
- A capture updates prev and the FSM state even when its push is dropped.
- Pop occurs on an edge where out_valid=1 and out_ready=1. Entries leave in order pushed.
- Push with FIFO full:
  - If a pop happens on the same edge, the push is accepted and fill is unchanged.
  - Otherwise the push is discarded, drop_cnt increments (saturating at 255), and fill stays at DEPTH.
- Push with FIFO empty: the entry is visible on out_* after that edge. There is no combinational bypass from in_val to out_*.
- out_ready with out_valid=0 is ignored.
- Reset clears:
  - phase, prev, fill, drop_cnt, and the FIFO pointers.
  - out_valid=0; out_data, out_delta and out_first read 0.
  - FSM returns to PRIME.
- Reset mid-operation discards all buffered entries. The next capture has first=1.

## Timing
- Reset values: out_valid=0, out_data=0, out_delta=0, out_first=0, fill=0, drop_cnt=0.
- Latency, en asserted to first capture: en rises before edge 1, so the first capture is on edge PERIOD, and out_valid=1 immediately after edge PERIOD.
- Sample spacing: exactly PERIOD enabled edges. Disabled cycles stretch the spacing without losing phase.
- out_* outputs are driven from registers/storage only. out_valid, fill and drop_cnt update on the same edge as the push or pop.
- Throughput: one pop per cycle. The FIFO never backpressures in_val.

## Test plan
1. **Reset.** Assert rst mid-cycle with no clock edge → all outputs 0 immediately. Release rst, hold en=0 for 10 cycles → out_valid stays 0, fill=0.
2. **Constant input.** WIDTH=16, PERIOD=4, DEPTH=4, in_val=0x0005, en=1, out_ready=1 → entry after edge 4: {0x0005, 0x0000, first=1}. Entry after edge 8: {0x0005, 0x0000, first=0}.
3. **Ramp input.** in_val=k before edge k (k=1,2,…), out_ready=1 → entries {4, 0, 1}, {8, 4, 0}, {12, 4, 0}.
4. **Wraparound.** Captured values are 0xFFFE, then 0x0002 → second entry has delta 0x0004, first=0.
5. **Overflow.** out_ready=0 for 6 captures of values 1..6 → fill=4, drop_cnt=2. Then set out_ready=1 → pops 1,2,3,4 on consecutive edges; fill ends at 0. The 7th capture has delta = its value − 6.
6. **Reset mid-operation.** Assert rst with fill=3 and the FSM in RUN → fill=0, out_valid=0. Release with en=1 → the next entry arrives after PERIOD edges with first=1, delta=0.
